// File: rtl/game_speed_ctrl.sv
// Accelerating game clock divider with run/pause/restart control and speed-level readout.
// Optional `GAME_SPEED_LOAD_EN adds a direct divider load (ports load, load_div).
module game_speed_ctrl #(
    parameter int unsigned CNT_W           = 28,
    parameter int unsigned START_DIV       = 160000,
    parameter int unsigned STEP_DIV        = 9000,
    parameter int unsigned MIN_DIV         = 97000,
    parameter int unsigned EVENTS_PER_STEP = 10000,
    parameter int unsigned EVT_W           = 15,
    parameter int unsigned LVL_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             restart,
`ifdef GAME_SPEED_LOAD_EN
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
`endif
    output logic             clk_div,
    output logic             tick,
    output logic [LVL_W-1:0] level,
    output logic             at_max
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;

    localparam logic [CNT_W-1:0] START_V      = CNT_W'(START_DIV);
    localparam logic [CNT_W-1:0] MIN_V        = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] STEP_V       = CNT_W'(STEP_DIV);
    localparam logic [CNT_W:0]   STEP_FLOOR   = (CNT_W+1)'(MIN_DIV) + (CNT_W+1)'(STEP_DIV);
    localparam logic [EVT_W-1:0] EVT_LAST     = EVT_W'(EVENTS_PER_STEP - 1);
    localparam logic             START_AT_MAX = (START_DIV == MIN_DIV);

    logic [1:0]       state,   state_n;
    logic [CNT_W-1:0] cnt,     cnt_n;
    logic [CNT_W-1:0] divider, div_n;
    logic [EVT_W-1:0] evt_cnt, evt_n;
    logic             clk_div_n, tick_n, at_max_n;
    logic [LVL_W-1:0] level_n;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            divider <= START_V;
            evt_cnt <= '0;
            clk_div <= 1'b1;
            tick    <= 1'b0;
            level   <= '0;
            at_max  <= START_AT_MAX;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            divider <= div_n;
            evt_cnt <= evt_n;
            clk_div <= clk_div_n;
            tick    <= tick_n;
            level   <= level_n;
            at_max  <= at_max_n;
        end
    end

    // Next-state, half-period counting and speed stepping
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_n     = divider;
        evt_n     = evt_cnt;
        clk_div_n = clk_div;
        tick_n    = 1'b0;
        level_n   = level;
        at_max_n  = at_max;
        if (restart) begin
            state_n   = S_IDLE;
            cnt_n     = '0;
            div_n     = START_V;
            evt_n     = '0;
            clk_div_n = 1'b1;
            level_n   = '0;
            at_max_n  = START_AT_MAX;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state_n = S_RUN;
                end
                S_RUN: begin
                    if (!run) begin
                        state_n = S_PAUSED;
                    end else if (cnt >= divider) begin
                        cnt_n     = '0;
                        clk_div_n = ~clk_div;
                        tick_n    = 1'b1;
                        if (evt_cnt == EVT_LAST) begin
                            evt_n = '0;
                            if ({1'b0, divider} >= STEP_FLOOR) div_n = divider - STEP_V;
                            else                                 div_n = MIN_V;
                            if ((divider != MIN_V) && !(&level)) level_n = level + LVL_W'(1);
                            at_max_n = (div_n == MIN_V);
                        end else begin
                            evt_n = evt_cnt + EVT_W'(1);
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_PAUSED: begin
                    if (run) state_n = S_RUN;
                end
                default: state_n = S_IDLE;
            endcase
`ifdef GAME_SPEED_LOAD_EN
            // A load overrides any step result computed in the same cycle
            if (load) begin
                div_n    = (load_div < MIN_V) ? MIN_V : load_div;
                evt_n    = '0;
                at_max_n = (div_n == MIN_V);
            end
`endif
        end
    end

endmodule
